// File: rtl/global_config_pkg.sv
// Shared types and sizing for the instruction buffer.
// Defining IBUF_BYPASS_EN adds the empty-buffer bypass path.
package global_config_pkg;

    localparam int IBUF_FETCH_W  = 4;
    localparam int IBUF_DECODE_W = 4;
    localparam int IBUF_DEPTH    = 16;
    localparam int IBUF_XLEN     = 32;
    localparam int IBUF_PTR_W    = $clog2(IBUF_DEPTH);
    localparam int IBUF_CNT_W    = IBUF_PTR_W + 1;

    typedef struct packed {
        logic        valid;
        logic        ready;
    } handshake_t;

    typedef struct packed {
        logic [IBUF_XLEN-1:0] pc;
        logic [31:0]          instr;
    } ibuf_entry_t;

endpackage

// File: rtl/ibuf_compact.sv
// Packs the set slots of a fetch group to the low end, in order.
// PCs come from the original slot position, not the packed one.
module ibuf_compact
    import global_config_pkg::*;
#(
    parameter int FETCH_W = IBUF_FETCH_W,
    parameter int NW      = $clog2(FETCH_W + 1)
) (
    input  logic [FETCH_W-1:0]      fe_mask_i,
    input  logic [IBUF_XLEN-1:0]    fe_pc_i,
    input  logic [FETCH_W*32-1:0]   fe_instr_i,
    output ibuf_entry_t [FETCH_W-1:0] ent_o,
    output logic [NW-1:0]           cnt_o
);

    logic [NW-1:0] pre [FETCH_W+1];

    always_comb begin
        pre[0] = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            pre[i+1] = pre[i] + NW'(fe_mask_i[i]);
        end
    end

    always_comb begin
        ent_o = '0;
        for (int j = 0; j < FETCH_W; j++) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (fe_mask_i[i] && pre[i] == NW'(j)) begin
                    ent_o[j].pc    = fe_pc_i + IBUF_XLEN'(4 * i);
                    ent_o[j].instr = fe_instr_i[32*i +: 32];
                end
            end
        end
        cnt_o = pre[FETCH_W];
    end

endmodule

// File: rtl/instr_buffer.sv
// Circular instruction queue between fetch and decode.
// Optional IBUF_BYPASS_EN forwards groups into an empty buffer same-cycle.
module instr_buffer
    import global_config_pkg::*;
#(
    parameter int FETCH_W  = IBUF_FETCH_W,
    parameter int DECODE_W = IBUF_DECODE_W,
    parameter int DEPTH    = IBUF_DEPTH,
    parameter int XLEN     = IBUF_XLEN
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     fe_valid_i,
    output logic                     fe_ready_o,
    input  logic [XLEN-1:0]          fe_pc_i,
    input  logic [FETCH_W-1:0]       fe_mask_i,
    input  logic [FETCH_W*32-1:0]    fe_instr_i,
    output logic [DECODE_W-1:0]      de_valid_o,
    output logic [DECODE_W*XLEN-1:0] de_pc_o,
    output logic [DECODE_W*32-1:0]   de_instr_o,
    input  logic                     de_ready_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NW    = $clog2(FETCH_W + 1);
    localparam int XW    = FETCH_W + DECODE_W;

    ibuf_entry_t                mem [DEPTH];
    logic [PTR_W-1:0]           head, tail;
    logic [CNT_W-1:0]           count;

    ibuf_entry_t [FETCH_W-1:0]  cmp;
    ibuf_entry_t [XW-1:0]       cmp_x;
    ibuf_entry_t [FETCH_W-1:0]  wsrc;
    ibuf_entry_t [DECODE_W-1:0] view;
    logic [NW-1:0]              n_enq;
    logic [CNT_W-1:0]           n_out, n_byp, n_show;
    logic [CNT_W-1:0]           n_deq, n_skip, n_wr;
    logic                       enq, byp;

    ibuf_compact #(
        .FETCH_W (FETCH_W),
        .NW      (NW)
    ) u_compact (
        .fe_mask_i  (fe_mask_i),
        .fe_pc_i    (IBUF_XLEN'(fe_pc_i)),
        .fe_instr_i (fe_instr_i),
        .ent_o      (cmp),
        .cnt_o      (n_enq)
    );

    always_comb begin
        fe_ready_o = (CNT_W'(DEPTH) - count >= CNT_W'(FETCH_W))
                     && !flush_i;
        enq   = fe_valid_i && fe_ready_o;
        n_out = (count > CNT_W'(DECODE_W)) ? CNT_W'(DECODE_W) : count;
`ifdef IBUF_BYPASS_EN
        byp   = enq && (count == '0);
`else
        byp   = 1'b0;
`endif
        n_byp = '0;
        if (byp) begin
            n_byp = (CNT_W'(n_enq) > CNT_W'(DECODE_W))
                    ? CNT_W'(DECODE_W) : CNT_W'(n_enq);
        end
        n_show = byp ? n_byp : n_out;
        n_deq  = (de_ready_i && !flush_i && !byp) ? n_out : '0;
        n_skip = (byp && de_ready_i) ? n_byp : '0;
        n_wr   = enq ? CNT_W'(n_enq) - n_skip : '0;
    end

    // Zero-extended copy so skipped/bypassed slots index safely
    always_comb begin
        cmp_x = '0;
        cmp_x[FETCH_W-1:0] = cmp;
        wsrc = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            for (int k = 0; k <= DECODE_W; k++) begin
                if (n_skip == CNT_W'(k)) wsrc[i] = cmp_x[i+k];
            end
        end
        view = '0;
        for (int s = 0; s < DECODE_W; s++) begin
            view[s] = byp ? cmp_x[s] : mem[head + PTR_W'(s)];
        end
    end

    always_comb begin
        de_valid_o = '0;
        de_pc_o    = '0;
        de_instr_o = '0;
        for (int s = 0; s < DECODE_W; s++) begin
            if (CNT_W'(s) < n_show && !flush_i) begin
                de_valid_o[s]           = 1'b1;
                de_pc_o[s*XLEN +: XLEN] = XLEN'(view[s].pc);
                de_instr_o[s*32 +: 32]  = view[s].instr;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (CNT_W'(i) < n_wr && !flush_i) begin
                mem[tail + PTR_W'(i)] <= wsrc[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_deq);
            tail  <= tail + PTR_W'(n_wr);
            count <= count + n_wr - n_deq;
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Scoreboard bench for instr_buffer with a queue-based reference model.
// Build with IBUF_BYPASS_EN defined to cover the bypass variant.
module tb_instr_buffer;

    localparam int FW = 4;
    localparam int DW = 4;
    localparam int D  = 16;
    localparam int XL = 32;
`ifdef IBUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             fe_valid = 1'b0;
    logic             fe_ready;
    logic [XL-1:0]    fe_pc = '0;
    logic [FW-1:0]    fe_mask = '0;
    logic [FW*32-1:0] fe_instr = '0;
    logic [DW-1:0]    de_valid;
    logic [DW*XL-1:0] de_pc;
    logic [DW*32-1:0] de_instr;
    logic             de_ready = 1'b0;

    instr_buffer dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .fe_valid_i (fe_valid),
        .fe_ready_o (fe_ready),
        .fe_pc_i    (fe_pc),
        .fe_mask_i  (fe_mask),
        .fe_instr_i (fe_instr),
        .de_valid_o (de_valid),
        .de_pc_o    (de_pc),
        .de_instr_o (de_instr),
        .de_ready_i (de_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [63:0] e [FW];
    } grp_t;

    logic [63:0] model [$];
    grp_t        grp_q [$];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want,
                     $time);
        end
    endtask

    function automatic grp_t make_grp(input logic [FW-1:0] m,
                                      input logic [XL-1:0] pc,
                                      input logic [FW*32-1:0] ins);
        grp_t g;
        g.n = 0;
        for (int i = 0; i < FW; i++) g.e[i] = '0;
        for (int i = 0; i < FW; i++) begin
            if (m[i]) begin
                g.e[g.n] = {pc + XL'(4 * i), ins[32*i +: 32]};
                g.n++;
            end
        end
        return g;
    endfunction

    // Drive one cycle of inputs; returns one tick past the next rising edge
    task automatic drive(input logic v, input logic [FW-1:0] m,
                         input logic [XL-1:0] pc, input logic rdy,
                         input logic fl);
        logic [FW*32-1:0] ins;
        for (int i = 0; i < FW; i++) ins[32*i +: 32] = $urandom();
        fe_valid = v;
        fe_mask  = m;
        fe_pc    = pc;
        fe_instr = ins;
        de_ready = rdy;
        flush    = fl;
        if (v) grp_q.push_back(make_grp(m, pc, ins));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, '0, '0, rdy, 1'b0);
    endtask

    function automatic logic [XL-1:0] rpc();
        return $urandom() & 32'hFFFF_FFFC;
    endfunction

    always @(negedge clk) begin
        grp_t        g;
        logic [63:0] view [$];
        logic [63:0] want;
        logic        exp_rdy, acc;
        int          nv, npop;
        g.n = 0;
        for (int i = 0; i < FW; i++) g.e[i] = '0;
        if (fe_valid) begin
            if (grp_q.size() == 0) begin
                errors++;
                $display("FAIL grp_q: got empty want group");
            end else begin
                g = grp_q.pop_front();
            end
        end
        if (rst) begin
            model.delete();
            check("rst_ready", 64'(fe_ready), 64'(!flush));
            check("rst_valid", 64'(de_valid), 64'd0);
            check("rst_pc", 64'(de_pc[XL-1:0]), 64'd0);
        end else begin
            exp_rdy = (D - model.size() >= FW) && !flush;
            acc     = fe_valid && exp_rdy;
            if (BYP && acc && model.size() == 0) begin
                view.delete();
                for (int i = 0; i < g.n; i++) view.push_back(g.e[i]);
            end else begin
                view = model;
            end
            nv = flush ? 0 : (view.size() < DW ? view.size() : DW);
            check("fe_ready", 64'(fe_ready), 64'(exp_rdy));
            check("de_valid", 64'(de_valid), 64'((1 << nv) - 1));
            for (int s = 0; s < DW; s++) begin
                want = (s < nv) ? view[s] : 64'd0;
                check($sformatf("slot%0d", s),
                      {de_pc[s*XL +: XL], de_instr[s*32 +: 32]}, want);
            end
            if (flush) begin
                model.delete();
            end else if (BYP && acc && model.size() == 0) begin
                for (int i = 0; i < g.n; i++) model.push_back(g.e[i]);
                if (de_ready) begin
                    npop = g.n < DW ? g.n : DW;
                    repeat (npop) void'(model.pop_front());
                end
            end else begin
                if (de_ready) begin
                    npop = model.size() < DW ? model.size() : DW;
                    repeat (npop) void'(model.pop_front());
                end
                if (acc) begin
                    for (int i = 0; i < g.n; i++) model.push_back(g.e[i]);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(1'b1);

        drive(1'b1, 4'b1111, 32'h8000_0000, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        drive(1'b1, 4'b1010, 32'h0000_1000, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);

        for (int k = 0; k < 5; k++) drive(1'b1, 4'b1111, rpc(), 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        repeat (5) idle(1'b1);

        for (int k = 0; k < 6; k++)
            drive(1'b1, 4'b1111, 32'h2000_0000 + 32'(k * 16), 1'b1, 1'b0);
        repeat (3) idle(1'b1);

        drive(1'b1, 4'b1111, rpc(), 1'b0, 1'b0);
        drive(1'b1, 4'b1111, rpc(), 1'b0, 1'b0);
        drive(1'b1, 4'b1111, rpc(), 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b1);

        drive(1'b1, 4'b0000, rpc(), 1'b1, 1'b0);
        drive(1'b1, 4'b0110, rpc(), 1'b0, 1'b0);
        drive(1'b1, 4'b1001, rpc(), 1'b0, 1'b0);
        idle(1'b0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1'b1);

        for (int k = 0; k < 600; k++) begin
            int pr;
            pr = (k < 200) ? 30 : (k < 400) ? 70 : 90;
            drive(($urandom_range(99) < 75), 4'($urandom()), rpc(),
                  ($urandom_range(99) < pr), ($urandom_range(99) < 3));
        end
        repeat (6) idle(1'b1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
